// File: rtl/joint_rcservo_multi_if.sv
// Command/status bundle between the joint command register file and the
// multi-channel RC-servo pulse generator.
interface joint_rcservo_multi_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]    enable;
  logic [NUM_CH-1:0]    mode;
  logic [NUM_CH*32-1:0] jointFreqCmd;
  logic [NUM_CH*32-1:0] jointPosCmd;
  logic [NUM_CH*32-1:0] jointFeedback;
  logic [NUM_CH-1:0]    PWM;
  logic                 frame_start;

  modport master (
    output enable, mode, jointFreqCmd, jointPosCmd,
    input  jointFeedback, PWM, frame_start
  );

  modport slave (
    input  enable, mode, jointFreqCmd, jointPosCmd,
    output jointFeedback, PWM, frame_start
  );
endinterface

// File: rtl/joint_rcservo_multi.sv
// Multi-channel RC-servo pulse generator: one shared frame counter, per-channel
// velocity/position tracking and a pulse width latched once per frame.
module joint_rcservo_multi #(
  parameter int NUM_CH       = 4,
  parameter int SERVO_FREQ   = 480000,
  parameter int SERVO_CENTER = 72000,
  parameter int SERVO_MINMAX = 72000
) (
  input logic                  clk,
  input logic                  rst_n,
  joint_rcservo_multi_if.slave bus
);

  if (NUM_CH < 1 || NUM_CH > 16 || SERVO_MINMAX > SERVO_CENTER ||
      SERVO_CENTER + SERVO_MINMAX >= SERVO_FREQ) begin : g_bad_cfg
    $error("joint_rcservo_multi: illegal NUM_CH/SERVO_* parameter combination");
  end

  localparam logic        [31:0] FREQ_M1_U = 32'(SERVO_FREQ - 1);
  localparam logic        [31:0] CENTER_U  = 32'(SERVO_CENTER);
  localparam logic signed [31:0] MAX_S     = 32'(SERVO_MINMAX);
  localparam logic signed [31:0] MIN_S     = -MAX_S;
  localparam logic signed [31:0] INT_MIN_S = 32'sh8000_0000;

  logic [31:0]       cnt_r;
  logic              frame_start_r;
  logic              frame_tick_s;
  logic [NUM_CH-1:0] pwm_all_s;

  assign frame_tick_s    = (cnt_r == 32'd0);
  assign bus.frame_start = frame_start_r;
  assign bus.PWM         = pwm_all_s;

  // Shared frame counter (0..SERVO_FREQ-1) and its registered boundary strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r         <= 32'd0;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= frame_tick_s;
      if (cnt_r == FREQ_M1_U) begin
        cnt_r <= 32'd0;
      end else begin
        cnt_r <= cnt_r + 32'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic signed [31:0] freq_cmd_s;
    logic signed [31:0] pos_cmd_s;
    logic signed [31:0] tgt_s;
    logic signed [31:0] pos_r;
    logic signed [31:0] pos_nxt_s;
    logic signed [31:0] fb_r;
    logic        [31:0] abs_s;
    logic        [31:0] rate_r;
    logic        [31:0] rate_nxt_s;
    logic        [31:0] width_r;
    logic        [31:0] width_new_s;
    logic               pwm_r;
    logic               pwm_nxt_s;

    assign freq_cmd_s  = bus.jointFreqCmd[32*i +: 32];
    assign pos_cmd_s   = bus.jointPosCmd[32*i +: 32];
    assign width_new_s = CENTER_U + unsigned'(pos_r);
    assign pwm_all_s[i] = pwm_r;
    assign bus.jointFeedback[32*i +: 32] = fb_r;

    // Step period magnitude (most-negative command saturates) and clamped position target.
    always_comb begin
      if (freq_cmd_s == INT_MIN_S) begin
        abs_s = 32'h7FFF_FFFF;
      end else if (freq_cmd_s[31]) begin
        abs_s = unsigned'(-freq_cmd_s);
      end else begin
        abs_s = unsigned'(freq_cmd_s);
      end
      if (pos_cmd_s > MAX_S) begin
        tgt_s = MAX_S;
      end else if (pos_cmd_s < MIN_S) begin
        tgt_s = MIN_S;
      end else begin
        tgt_s = pos_cmd_s;
      end
    end

    // Next position / rate counter: frozen when disabled, tracking or integrating otherwise.
    always_comb begin
      pos_nxt_s  = pos_r;
      rate_nxt_s = rate_r;
      if (!bus.enable[i]) begin
        pos_nxt_s  = pos_r;
        rate_nxt_s = rate_r;
      end else if (bus.mode[i]) begin
        pos_nxt_s  = tgt_s;
        rate_nxt_s = 32'd0;
      end else if (freq_cmd_s == 32'sd0) begin
        rate_nxt_s = 32'd0;
      end else if (rate_r >= abs_s - 32'd1) begin
        rate_nxt_s = 32'd0;
        if (freq_cmd_s[31] && (pos_r > MIN_S)) begin
          pos_nxt_s = pos_r - 32'sd1;
        end else if (!freq_cmd_s[31] && (pos_r < MAX_S)) begin
          pos_nxt_s = pos_r + 32'sd1;
        end else begin
          pos_nxt_s = pos_r;
        end
      end else begin
        rate_nxt_s = rate_r + 32'd1;
      end
    end

    // Pulse rises after a frame boundary, falls at the latched width or on disable.
    always_comb begin
      if (frame_tick_s) begin
        pwm_nxt_s = bus.enable[i] && (width_new_s != 32'd0);
      end else if (!bus.enable[i]) begin
        pwm_nxt_s = 1'b0;
      end else if (cnt_r == width_r) begin
        pwm_nxt_s = 1'b0;
      end else begin
        pwm_nxt_s = pwm_r;
      end
    end

    // Per-channel state; the width only changes on an enabled frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pos_r   <= 32'sd0;
        rate_r  <= 32'd0;
        fb_r    <= 32'sd0;
        width_r <= CENTER_U;
        pwm_r   <= 1'b0;
      end else begin
        pos_r  <= pos_nxt_s;
        rate_r <= rate_nxt_s;
        fb_r   <= pos_r;
        pwm_r  <= pwm_nxt_s;
        if (frame_tick_s && bus.enable[i]) begin
          width_r <= width_new_s;
        end else begin
          width_r <= width_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_joint_rcservo_multi.sv
// Scoreboard bench for joint_rcservo_multi: stimulus queues expected pulse widths
// and feedback values, a monitor compares them as frames and samples complete.
module tb_joint_rcservo_multi;
  localparam int NUM_CH       = 2;
  localparam int SERVO_FREQ   = 100;
  localparam int SERVO_CENTER = 30;
  localparam int SERVO_MINMAX = 20;

  typedef struct { int frame; int ch; int w; } pulse_t;
  typedef struct { int cyc; int ch; int val; } fb_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  joint_rcservo_multi_if #(.NUM_CH(NUM_CH)) bus ();

  joint_rcservo_multi #(
    .NUM_CH(NUM_CH), .SERVO_FREQ(SERVO_FREQ),
    .SERVO_CENTER(SERVO_CENTER), .SERVO_MINMAX(SERVO_MINMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  pulse_t pq[$];
  fb_t    fq[$];
  int     n_chk = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     gf = -1;
  bit     in_frame = 1'b0;
  int     idx = 0;
  int     hi[NUM_CH];
  bit     contig[NUM_CH];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_pulse(input int f, input int w0, input int w1);
    pq.push_back('{f, 0, w0});
    pq.push_back('{f, 1, w1});
  endtask

  task automatic push_fb(input int c, input int ch, input int v);
    fq.push_back('{c, ch, v});
  endtask

  task automatic set_freq(input int ch, input logic [31:0] v);
    bus.jointFreqCmd[32*ch +: 32] = v;
  endtask

  task automatic set_pos(input int ch, input logic [31:0] v);
    bus.jointPosCmd[32*ch +: 32] = v;
  endtask

  task automatic at_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // Monitor: closes a frame on each frame_start, counts pulse samples, checks feedback.
  initial begin
    pulse_t pe;
    fb_t    fe;
    int     v;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        cyc      = 0;
        in_frame = 1'b0;
      end else begin
        cyc++;
        if (bus.frame_start) begin
          chk($sformatf("frame_start phase @%0d", cyc), cyc % SERVO_FREQ, 1);
          if (in_frame) begin
            while (pq.size() > 0 && pq[0].frame <= gf) begin
              pe = pq.pop_front();
              if (pe.frame != gf) begin
                chk($sformatf("pulse frame ch%0d", pe.ch), gf, pe.frame);
              end else begin
                chk($sformatf("pulse width f%0d ch%0d", gf, pe.ch), hi[pe.ch], pe.w);
                chk($sformatf("pulse contiguous f%0d ch%0d", gf, pe.ch), int'(contig[pe.ch]), 1);
              end
            end
          end
          gf++;
          in_frame = 1'b1;
          idx      = 0;
          for (int c = 0; c < NUM_CH; c++) begin
            hi[c]     = 0;
            contig[c] = 1'b1;
          end
        end
        if (in_frame) begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (bus.PWM[c]) begin
              if (hi[c] != idx) contig[c] = 1'b0;
              hi[c]++;
            end
          end
          idx++;
        end
        while (fq.size() > 0 && fq[0].cyc <= cyc) begin
          fe = fq.pop_front();
          v  = $signed(bus.jointFeedback[32*fe.ch +: 32]);
          if (fe.cyc == cyc) begin
            chk($sformatf("feedback ch%0d @%0d", fe.ch, fe.cyc), v, fe.val);
          end else begin
            chk($sformatf("feedback sample missed ch%0d", fe.ch), cyc, fe.cyc);
          end
        end
      end
    end
  end

  // Stimulus: directed phases, each pushing its hand-computed expectations first.
  initial begin
    rst_n            = 1'b0;
    bus.enable       = 2'b11;
    bus.mode         = 2'b00;
    bus.jointFreqCmd = '0;
    bus.jointPosCmd  = '0;
    repeat (3) @(negedge clk);
    push_pulse(0, 30, 30);
    push_pulse(1, 30, 30);
    push_fb(50, 0, 0);
    push_fb(50, 1, 0);
    rst_n = 1'b1;

    // velocity: ch0 +5 saturating at +20, ch1 -3 saturating at -20
    at_cyc(100);
    push_pulse(2, 50, 10);
    push_fb(103, 1, 0);   push_fb(104, 1, -1);
    push_fb(105, 0, 0);   push_fb(106, 0, 1);
    push_fb(110, 0, 1);   push_fb(111, 0, 2);
    push_fb(160, 1, -19); push_fb(161, 1, -20);
    push_fb(190, 1, -20); push_fb(201, 0, 20);
    push_fb(250, 0, 20);
    set_freq(0, 32'd5);
    set_freq(1, -32'sd3);

    at_cyc(200);
    push_pulse(3, 37, 10);
    set_freq(1, 32'h8000_0000);

    // position mode: 7 then 500 (clamped to 20)
    at_cyc(250);
    push_fb(251, 0, 20); push_fb(252, 0, 7);
    push_fb(321, 0, 7);  push_fb(322, 0, 20);
    bus.mode[0] = 1'b1;
    set_pos(0, 32'd7);

    at_cyc(320);
    push_pulse(4, 50, 30);
    push_fb(332, 1, 0);
    push_fb(399, 1, 0);
    set_pos(0, 32'd500);

    // ch1: park at 0, then integrate the most-negative command without wrapping
    at_cyc(330);
    bus.mode[1] = 1'b1;
    set_pos(1, 32'd0);
    at_cyc(340);
    bus.mode[1] = 1'b0;

    // mid-frame position change does not alter the running pulse
    at_cyc(450);
    push_pulse(5, 30, 30);
    push_pulse(6, 45, 30);
    push_fb(511, 0, 0);
    push_fb(512, 0, 15);
    set_pos(0, 32'd0);
    at_cyc(510);
    set_pos(0, 32'd15);

    // disable ch0 mid-pulse, re-enable mid-frame
    at_cyc(650);
    push_pulse(7, 15, 30);
    push_fb(740, 0, 0);
    push_fb(751, 0, 0);
    push_fb(752, 0, 9);
    set_pos(0, 32'd0);
    at_cyc(715);
    bus.enable[0] = 1'b0;
    at_cyc(720);
    set_pos(0, 32'd9);
    at_cyc(750);
    push_pulse(8, 39, 30);
    push_fb(850, 1, 0);
    bus.enable[0] = 1'b1;

    // asynchronous reset in the middle of both pulses
    at_cyc(910);
    chk("pwm before reset", int'(bus.PWM), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("pwm in reset", int'(bus.PWM), 0);
    chk("frame_start in reset", int'(bus.frame_start), 0);
    chk("feedback ch0 in reset", $signed(bus.jointFeedback[31:0]), 0);
    chk("feedback ch1 in reset", $signed(bus.jointFeedback[63:32]), 0);
    push_pulse(10, 30, 30);
    push_pulse(11, 39, 30);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    at_cyc(205);
    chk("pulse queue drained", pq.size(), 0);
    chk("feedback queue drained", fq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/joint_rcservo_multi.md
Name: joint_rcservo_multi

Overview:
- Multi-channel RC-servo pulse generator; the parametrised successor of the single-channel RC-servo joint.
- One shared frame counter drives NUM_CH PWM outputs. Every channel starts its pulse on the same frame boundary.
- Each channel runs independently in one of two modes:
  - velocity mode: integrates a signed step-rate command into a clamped position;
  - position mode: tracks a clamped absolute position command.
- Pulse width is latched once per frame, so outputs are glitch-free. Sits between the joint command register file and the servo output pins.

Parameters:
- NUM_CH, 4, number of servo channels (1..16).
- SERVO_FREQ, 480000, frame period in clk cycles.
- SERVO_CENTER, 72000, pulse width in clk cycles at position 0.
- SERVO_MINMAX, 72000, symmetric position limit; position range is [-SERVO_MINMAX, +SERVO_MINMAX] inclusive.
- Elaboration error unless SERVO_MINMAX <= SERVO_CENTER and SERVO_CENTER + SERVO_MINMAX < SERVO_FREQ.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  NUM_CH  per-channel enable
- mode  in  NUM_CH  per-channel mode: 0 = velocity, 1 = position
- jointFreqCmd  in  NUM_CH*32  packed signed step-period commands; channel i at [32*i+31:32*i]
- jointPosCmd  in  NUM_CH*32  packed signed absolute position commands
- jointFeedback  out  NUM_CH*32  packed signed current positions
- PWM  out  NUM_CH  servo pulse outputs
- frame_start  out  1  one-cycle strobe at each frame boundary

Behaviour:
- Reset (async assert, sync release):
  - frame counter = 0; all positions, rate counters and jointFeedback = 0;
  - PWM = 0; frame_start = 0; latched widths = SERVO_CENTER.
- Frame counter counts 0..SERVO_FREQ-1, then wraps to 0. Frame period is exactly SERVO_FREQ cycles.
- On the cycle the counter is 0:
  - frame_start = 1 (registered, one cycle);
  - each enabled channel latches width_i = SERVO_CENTER + pos_i (position as registered that cycle);
  - PWM_i goes high on the next edge.
- PWM_i falls when counter == width_i. High time is exactly width_i cycles. width_i = 0 gives no pulse.
- width_i is not affected by position changes mid-frame.
- Disabled channel:
  - PWM_i forced low on the next edge, including mid-pulse;
  - position and rate counter frozen;
  - re-enable takes effect at the next frame boundary, never mid-frame.
- Velocity mode (mode_i = 0, enabled):
  - abs_i = |cmd_i|; -2^31 saturates to 2^31-1.
  - cmd_i = 0: rate counter held at 0, no motion.
  - Otherwise the rate counter increments each cycle. When rate_cnt >= abs_i - 1: rate_cnt <= 0 and pos_i steps by +1 (cmd > 0) or -1 (cmd < 0). Result: one step every abs_i cycles.
  - A step that would exceed ±SERVO_MINMAX is suppressed; the position holds at the limit and never wraps.
  - A command change does not reset the rate counter. The >= compare guarantees a step within one cycle when the new period is shorter.
- Position mode (mode_i = 1, enabled):
  - pos_i <= clamp(jointPosCmd_i, ±SERVO_MINMAX) every cycle;
  - rate counter held at 0.
- Mode switch:
  - position to velocity: integration continues from the current pos_i, no jump;
  - velocity to position: pos_i takes the clamped target on the next edge.
- jointFeedback_i is the registered pos_i, one cycle after an update.
- Channels are fully independent; simultaneous steps on all channels are legal.
- Reset mid-frame: all outputs return to reset values immediately. The first frame_start after release comes on the first counted cycle.

Test Plan:
- Common bench settings: NUM_CH=2, SERVO_FREQ=100, SERVO_CENTER=30, SERVO_MINMAX=20.
- Reset then enable=2'b11, mode=0, cmds 0:
  - frame_start every 100 cycles;
  - both PWM high exactly 30 cycles, starting in the same cycle;
  - jointFeedback = 0.
- Ch0 velocity cmd=+5:
  - jointFeedback0 increments every 5 cycles;
  - saturates at +20 after 100 cycles and stays there;
  - next frame PWM0 high 50 cycles.
- Ch1 velocity cmd=-3 from 0:
  - reaches -20 after 60 cycles, holds;
  - PWM1 high 10 cycles.
  - cmd=-2^31 on ch1: no wrap, position decrements at most once per 2^31-1 cycles.
- Ch0 position mode, jointPosCmd0 = 7 then = 500:
  - feedback 7 next cycle, then 20 (clamped);
  - PWM0 width 37 in the frame where 7 was latched.
- Position change mid-frame (cycle 10, from 0 to 15 via position mode):
  - current pulse still 30 cycles;
  - following frame 45 cycles.
- Deassert enable0 at cycle 15 of a frame:
  - PWM0 low at cycle 16, feedback frozen;
  - reassert at cycle 50: PWM0 stays low until the next frame, then normal width.
- Assert rst_n low mid-pulse:
  - PWM, frame_start, feedback = 0 asynchronously;
  - after release, the frame restarts from counter 0.
